// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: holds the program image, accepts a program
// load before execution starts, then returns one registered instruction word
// per cycle for the address presented by the PC.
module instr_mem_responder #(
  parameter int                ADDR_W   = 11,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2048,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              Clock_i,
  input  logic              Reset_i,
  input  logic [ADDR_W-1:0] Endereco_i,
  input  logic              Stall_i,
  input  logic              Flush_i,
  input  logic              Start_i,
  input  logic              LoadEn_i,
  input  logic [ADDR_W-1:0] LoadAddr_i,
  input  logic [DATA_W-1:0] LoadData_i,
  output logic [DATA_W-1:0] Instrucao_o,
  output logic              InstrValida_o,
  output logic              Busy_o,
  output logic              AddrErro_o,
  output logic [15:0]       FetchCount_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_q;
  logic [15:0]       cnt_q;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Both ranges are plain unsigned compares; no address ever wraps into the array.
  logic              ld_in_range;
  logic              rd_in_range;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  assign ld_in_range = 32'(LoadAddr_i) < 32'(DEPTH);
  assign rd_in_range = 32'(Endereco_i) < 32'(DEPTH);
  // Writes only land outside RUN, so a fetch never races a write.
  assign wr_en       = !Reset_i && LoadEn_i && (state_q != S_RUN) && ld_in_range;
  assign rd_data     = mem[Endereco_i[IDX_W-1:0]];

  // Program image: no reset, contents survive a pipeline reset.
  always_ff @(posedge Clock_i) begin
    if (wr_en) mem[LoadAddr_i[IDX_W-1:0]] <= LoadData_i;
  end

  // Control FSM plus the registered fetch port, error flag and fetch counter.
  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q <= S_IDLE;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
          // A load strobe wins over Start; the first word is written this edge.
          if (LoadEn_i) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end else if (Start_i) begin
            state_q <= S_RUN;
          end
        end
        S_LOAD: begin
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
          if (Start_i) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          // Flush beats Stall; Stall freezes word, valid and count.
          if (Flush_i) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
          end else if (!Stall_i) begin
            if (rd_in_range) begin
              instr_q <= rd_data;
              valid_q <= 1'b1;
              if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end else begin
              instr_q <= NOP_WORD;
              valid_q <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Instrucao_o   = instr_q;
  assign InstrValida_o = valid_q;
  assign Busy_o        = busy_q;
  assign AddrErro_o    = err_q;
  assign FetchCount_o  = cnt_q;

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory side of the PC-to-instruction-memory interface.
- Takes the 11-bit instruction address from the PC and returns the 32-bit instruction word through a registered, one-cycle-latency read port.
- Adds a program-load write port, stall/flush control from the pipeline, an out-of-range error flag and a saturating fetch counter.
- Sits between the PC register and the decode/register-file stage.

Parameters:
- ADDR_W, 11, instruction address width; matches the PC output.
- DATA_W, 32, instruction word width.
- DEPTH, 2048, number of implemented words; must be ≤ 2**ADDR_W.
- NOP_WORD, 32'h0000_0000, word driven when no valid instruction is available.

Ports:
- Clock  in  1  system clock; all logic updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Endereco  in  ADDR_W  instruction address from the PC.
- Stall  in  1  hold the current output word; do not fetch.
- Flush  in  1  discard the next fetched word (branch/jump taken).
- Start  in  1  single-cycle pulse: leave IDLE/LOAD and enter RUN.
- LoadEn  in  1  program-load write strobe.
- LoadAddr  in  ADDR_W  program-load address.
- LoadData  in  DATA_W  program-load word.
- Instrucao  out  DATA_W  registered instruction word to decode.
- InstrValida  out  1  Instrucao holds a real fetched instruction.
- Busy  out  1  high in LOAD state.
- AddrErro  out  1  sticky flag: an out-of-range fetch occurred.
- FetchCount  out  16  saturating count of valid fetches.

Behaviour:
- Reset (dominates all other inputs):
  - state = IDLE; Instrucao = NOP_WORD; InstrValida = 0; Busy = 0; AddrErro = 0; FetchCount = 0.
  - Memory contents are NOT cleared.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: LoadEn → LOAD, and the write is performed that same edge. Start without LoadEn → RUN. Otherwise stay.
  - LOAD: Busy = 1. Each edge with LoadEn writes mem[LoadAddr] = LoadData; a LoadAddr ≥ DEPTH write is dropped silently. Start → RUN; if LoadEn is also high that edge, the write still happens first.
  - RUN: LoadEn is ignored (no self-modification). Start is ignored. The only exit is Reset.
- Outputs in IDLE/LOAD: Instrucao = NOP_WORD, InstrValida = 0.
- RUN fetch, evaluated each edge in this priority order:
  1. Flush: Instrucao ← NOP_WORD, InstrValida ← 0. No counter increment. Flush overrides Stall.
  2. Stall: Instrucao and InstrValida hold. FetchCount holds.
  3. Otherwise, Endereco < DEPTH: Instrucao ← mem[Endereco], InstrValida ← 1, FetchCount ← FetchCount + 1, saturating at 16'hFFFF.
  4. Otherwise, Endereco ≥ DEPTH: Instrucao ← NOP_WORD, InstrValida ← 0, AddrErro ← 1 (stays set until Reset).
- Latency:
  - Address presented before edge N appears on Instrucao after edge N. Exactly one cycle; no combinational path from Endereco to Instrucao.
  - The first RUN fetch happens on the edge after the Start edge, so the PC's first address (0) is sampled on that edge.
- Read-during-write cannot occur (writes only outside RUN).
- Address arithmetic: unsigned ADDR_W compare against DEPTH. No wrap-around; out-of-range is an error, not a modulo.

Test Plan:
1. Reset, LoadEn with LoadAddr 0..3 = 32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'hAC0A_0000 (Busy = 1 during load), then Start. Drive Endereco 0,1,2,3 on successive cycles → Instrucao shows those words one cycle later each; InstrValida = 1; FetchCount = 4.
2. Stall high for 3 cycles while Endereco changes 1→2→3 → Instrucao stays 32'h2009_0003, FetchCount unchanged. Release → resumes at current Endereco next edge.
3. Flush and Stall together at Endereco = 2 → next cycle Instrucao = 0, InstrValida = 0, FetchCount unchanged. Following cycle fetches normally.
4. DEPTH = 1024 build, Endereco = 11'd1500 in RUN → Instrucao = 0, InstrValida = 0, AddrErro = 1 and stays 1 after valid fetches resume. LoadAddr = 1500 write in LOAD is dropped.
5. LoadEn in RUN with LoadAddr = 0, LoadData = 32'hFFFF_FFFF → mem[0] unchanged (refetch returns 32'h2008_0005).
6. Reset asserted mid-RUN → next edge: IDLE, Instrucao = 0, InstrValida = 0, AddrErro = 0, FetchCount = 0. After Start, Endereco = 0 still returns 32'h2008_0005 (memory retained).
